// File: rtl/sevseg_bank_ctrl.sv
// Avalon-MM register bank driving NUM_DIGITS active-low seven-segment digits with blink and blank.
// Optional build macro SEVSEG_BCD_DECODE_EN adds a per-digit hex-decode flag in DIGIT bit 7.
module sevseg_bank_ctrl #(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25000000,
   parameter int ADDR_W     = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       address,
   input  logic                    chipselect,
   input  logic                    write_n,
   input  logic [31:0]             writedata,
   output logic [31:0]             readdata,
   output logic [NUM_DIGITS*7-1:0] out_port
);

`ifdef SEVSEG_BCD_DECODE_EN
   localparam int DIGIT_W = 8;
`else
   localparam int DIGIT_W = 7;
`endif
   localparam int CNT_W = $clog2(BLINK_DIV);

   localparam logic [ADDR_W-1:0] ADDR_MASK   = ADDR_W'(8);
   localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(9);
   localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(10);
   localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(BLINK_DIV - 1);

   logic [DIGIT_W-1:0]      digit_q [NUM_DIGITS];
   logic [DIGIT_W-1:0]      digit_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   blink_mask_q, blink_mask_d;
   logic                    blank_all_q, blank_all_d;
   logic                    blink_en_q, blink_en_d;
   logic                    phase_q, phase_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NUM_DIGITS*7-1:0] out_q, out_d;

   logic wr_en;
   logic ctrl_wr;
   logic [6:0] seg_value;
   logic unused_wdata;

   assign wr_en   = chipselect && !write_n;
   assign ctrl_wr = wr_en && (address == ADDR_CTRL);
   assign unused_wdata = ^writedata;

`ifdef SEVSEG_BCD_DECODE_EN
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction
`endif

   function automatic logic [6:0] digit_seg(input logic [DIGIT_W-1:0] d);
`ifdef SEVSEG_BCD_DECODE_EN
      if (d[7]) return hex_to_seg(d[3:0]);
`endif
      return d[6:0];
   endfunction

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      digit_d      = digit_q;
      blink_mask_d = blink_mask_q;
      blank_all_d  = blank_all_q;
      blink_en_d   = blink_en_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (wr_en && (address == ADDR_W'(i))) digit_d[i] = writedata[DIGIT_W-1:0];
      end
      if (wr_en && (address == ADDR_MASK)) blink_mask_d = writedata[NUM_DIGITS-1:0];
      if (ctrl_wr) begin
         blank_all_d = writedata[0];
         blink_en_d  = writedata[1];
      end
   end

   // A CTRL write clearing blink_en parks the counter on the same edge; setting it counts from the next.
   always_comb begin
      cnt_d   = '0;
      phase_d = 1'b1;
      if (blink_en_q && !(ctrl_wr && !writedata[1])) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = !phase_q;
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = phase_q;
         end
      end
   end

   always_comb begin
      out_d     = '1;
      seg_value = 7'h7F;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (blank_all_q || (blink_mask_q[i] && !phase_q)) seg_value = 7'h7F;
         else                                               seg_value = digit_seg(digit_q[i]);
         out_d[7*i +: 7] = seg_value;
      end
   end

   always_comb begin
      readdata = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (address == ADDR_W'(i)) readdata[DIGIT_W-1:0] = digit_q[i];
      end
      if (address == ADDR_MASK)   readdata[NUM_DIGITS-1:0] = blink_mask_q;
      if (address == ADDR_CTRL)   readdata[1:0] = {blink_en_q, blank_all_q};
      if (address == ADDR_STATUS) readdata[0] = phase_q;
   end

   // NOTE: state flops use non-blocking assignments only, so all flops sample pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the digit array is a handful of flops, not a RAM, so resetting it costs nothing special.
         for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= DIGIT_W'(7'h7F);
         blink_mask_q <= '0;
         blank_all_q  <= 1'b0;
         blink_en_q   <= 1'b0;
         phase_q      <= 1'b1;
         cnt_q        <= '0;
         out_q        <= '1;
      end else begin
         digit_q      <= digit_d;
         blink_mask_q <= blink_mask_d;
         blank_all_q  <= blank_all_d;
         blink_en_q   <= blink_en_d;
         phase_q      <= phase_d;
         cnt_q        <= cnt_d;
         out_q        <= out_d;
      end
   end

   assign out_port = out_q;

endmodule

// File: tb/tb_sevseg_bank_ctrl.sv
// Self-checking bench for sevseg_bank_ctrl: directed literal checks plus randomized traffic vs a model.
// Honours SEVSEG_BCD_DECODE_EN the same way as the design.
module tb_sevseg_bank_ctrl;
   localparam int NUM_DIGITS = 6;
   localparam int BLINK_DIV  = 4;
   localparam int ADDR_W     = 4;
   localparam int OUT_W      = NUM_DIGITS * 7;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic [OUT_W-1:0]  out_port;

   int n_checks = 0;
   int n_errors = 0;

   sevseg_bank_ctrl #(
      .NUM_DIGITS(NUM_DIGITS),
      .BLINK_DIV (BLINK_DIV),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .out_port  (out_port)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phase comes from the number of edges spent counting since blink was (re)started.
   logic [6:0]            hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [7:0]            m_digit [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] m_mask;
   logic                  m_blank, m_en;
   int                    m_n;
   logic [OUT_W-1:0]      m_out;
   bit                    started = 1'b0;

   function automatic bit m_phase();
      return ((m_n / BLINK_DIV) % 2) == 0;
   endfunction

   function automatic logic [6:0] m_seg(input int i);
      if (m_blank || (m_mask[i] && !m_phase())) return 7'h7F;
`ifdef SEVSEG_BCD_DECODE_EN
      if (m_digit[i][7]) return hex_tab[m_digit[i][3:0]];
`endif
      return m_digit[i][6:0];
   endfunction

   function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
      for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef SEVSEG_BCD_DECODE_EN
         if (a == ADDR_W'(i)) return {24'b0, m_digit[i]};
`else
         if (a == ADDR_W'(i)) return {25'b0, m_digit[i][6:0]};
`endif
      end
      if (a == 4'd8)  return {{(32-NUM_DIGITS){1'b0}}, m_mask};
      if (a == 4'd9)  return {30'b0, m_en, m_blank};
      if (a == 4'd10) return {31'b0, m_phase()};
      return 32'h0;
   endfunction

   always @(posedge clk) begin
      started <= 1'b1;
      if (reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) m_digit[i] <= 8'h7F;
         m_mask  <= '0;
         m_blank <= 1'b0;
         m_en    <= 1'b0;
         m_n     <= 0;
         m_out   <= '1;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) m_out[7*i +: 7] <= m_seg(i);
         if (chipselect && !write_n) begin
            for (int i = 0; i < NUM_DIGITS; i++)
               if (address == ADDR_W'(i)) m_digit[i] <= writedata[7:0];
            if (address == 4'd8) m_mask <= writedata[NUM_DIGITS-1:0];
            if (address == 4'd9) begin
               m_blank <= writedata[0];
               m_en    <= writedata[1];
            end
         end
         if (!m_en || (chipselect && !write_n && address == 4'd9 && !writedata[1])) m_n <= 0;
         else                                                                       m_n <= m_n + 1;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("out_port_vs_model", 64'(out_port), 64'(m_out));
         check("readdata_vs_model", 64'(readdata), 64'(m_read(address)));
      end
   end

   // ---------------- stimulus ----------------
   task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      check(name, 64'(readdata), 64'(exp));
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   logic [OUT_W-1:0] stored;
   logic [6:0]       blink_exp [10] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40,
                                        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
   logic             phase_exp [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                        1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      reset      = 1'b1;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_out_port", 64'(out_port), 64'({OUT_W{1'b1}}));
      rd("reset_ctrl", 4'd9, 32'h0);
      rd("reset_status", 4'd10, 32'h1);

      wr(4'd2, 32'h24);
      check("digit2_not_yet", 64'(out_port[20:14]), 64'(7'h7F));
      tick();
      stored = '1;
      stored[20:14] = 7'h24;
      check("digit2_shown", 64'(out_port), 64'(stored));
      rd("digit2_read", 4'd2, 32'h24);

      wr(4'd8, 32'h1);
      wr(4'd0, 32'h40);
      wr(4'd9, 32'h2);
      stored[6:0] = 7'h40;
      address = 4'd10;
      for (int t = 0; t < 10; t++) begin
         #1;
         check("blink_digit0", 64'(out_port[6:0]), 64'(blink_exp[t]));
         check("blink_others", 64'(out_port[OUT_W-1:7]), 64'(stored[OUT_W-1:7]));
         check("blink_phase", 64'(readdata), 64'({31'b0, phase_exp[t]}));
         @(posedge clk);
      end
      #1;
      wr(4'd9, 32'h0);
      rd("phase_forced", 4'd10, 32'h1);
      tick();
      check("blink_off_digit0", 64'(out_port[6:0]), 64'(7'h40));

      wr(4'd9, 32'h2);
      wr(4'd9, 32'h3);
      tick();
      check("blank_all", 64'(out_port), 64'({OUT_W{1'b1}}));
      wr(4'd9, 32'h0);
      tick();
      check("unblank_restore", 64'(out_port), 64'(stored));

      wr(4'd10, 32'h0);
      wr(4'd12, 32'hFFFF_FFFF);
      rd("unmapped_read", 4'd12, 32'h0);
      rd("status_unchanged", 4'd10, 32'h1);
      rd("mask_unchanged", 4'd8, 32'h1);
      rd("ctrl_unchanged", 4'd9, 32'h0);
      rd("digit2_unchanged", 4'd2, 32'h24);
      tick();
      check("unmapped_out", 64'(out_port), 64'(stored));

      wr(4'd0, 32'h8F);
      tick();
`ifdef SEVSEG_BCD_DECODE_EN
      check("bcd_digit0", 64'(out_port[6:0]), 64'(7'h0E));
      rd("bcd_read", 4'd0, 32'h8F);
`else
      check("raw_digit0", 64'(out_port[6:0]), 64'(7'h0F));
      rd("raw_read", 4'd0, 32'h0F);
`endif

      reset = 1'b1;
      tick();
      check("midrun_reset_out", 64'(out_port), 64'({OUT_W{1'b1}}));
      reset = 1'b0;

      for (int c = 0; c < 1500; c++) begin
         reset      = ($urandom_range(0, 199) == 0);
         chipselect = ($urandom_range(0, 3) != 0);
         write_n    = $urandom_range(0, 1) == 1;
         address    = ADDR_W'($urandom_range(0, 15));
         writedata  = $urandom;
         tick();
      end
      reset      = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
